// File: rtl/ifetch_unit_pkg.sv
// Shared widths, state encodings and fetch-entry layout for the instruction
// fetch front end.
package ifetch_unit_pkg;

    localparam int XLEN    = 32;
    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    // Fetch FSM encodings (kept as plain constants for legacy tools).
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] FAULT = 1'b1;

    // Canonical RISC-V NOP (addi x0, x0, 0).
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    // One buffered fetch: the address and the word that came back for it.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // A pc is fetchable when word aligned and inside the instruction memory.
    // Comparing pc>>2 against the row count avoids overflow of 4*imem_words.
    function automatic logic pc_is_legal(input logic [XLEN-1:0] pc,
                                         input int unsigned     imem_words);
        return (pc[1:0] == 2'b00) && ({2'b00, pc[XLEN-1:2]} < imem_words);
    endfunction

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Small synchronous circular-buffer FIFO with flush, used to hold fetched
// {pc, inst} pairs until decode accepts them. Pop-and-push when full is legal.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // Empty reads return zero so the head is clean after reset and flush.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer/count values; flush discards everything, pointers wrap
    // naturally because DEPTH is a power of two.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy is tracked by count_q, so stale rows are never visible.
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the pc, fetches from a combinational
// instruction memory, buffers {pc, inst} pairs and hands them to decode.
// Redirects flush wrong-path entries; illegal pcs park the unit in FAULT.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [0:0]      state_q, state_d;
    logic            push, flush, deq, can_enq, pc_legal;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    wr_entry, head_entry;

    assign imem_pc     = pc_q;
    assign out_valid   = !fifo_empty;
    assign out_pc      = head_entry.pc;
    assign out_inst    = head_entry.inst;
    assign fetch_fault = (state_q == FAULT);

    assign deq      = out_valid & out_ready;
    // A slot frees up this cycle if decode is taking the head.
    assign can_enq  = !fifo_full | deq;
    assign pc_legal = pc_is_legal(pc_q, IMEM_WORDS);
    assign wr_entry = '{pc: pc_q, inst: imem_inst};

    // Fetch decision: redirect first, then fault detection, then fetch.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_d    = redirect_pc;
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (!pc_legal) begin
                state_d = FAULT;
            end else if (can_enq) begin
                push = 1'b1;
                pc_d = pc_q + XLEN'(PC_STEP);
            end
        end
    end

    // PC and FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= FETCH;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (deq),
        .wdata (wr_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a directed vector table covering the documented
// scenarios, then randomized traffic against a queue-based reference model.
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    localparam int          DEPTH      = 2;
    localparam int unsigned IMEM_WORDS = 256;
    localparam logic [31:0] I0 = 32'h0020_81B3;
    localparam logic [31:0] I1 = 32'h4041_82B3;
    localparam logic [31:0] I2 = 32'h0053_2023;
    localparam logic [31:0] I3 = 32'h0003_2383;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fetch_fault;

    logic [31:0] imem [IMEM_WORDS];

    always #5 clk = ~clk;

    // Combinational instruction memory; out-of-range reads return garbage.
    always_comb begin
        imem_inst = 32'hDEAD_BEEF;
        if (imem_pc[31:10] == '0) imem_inst = imem[imem_pc[9:2]];
    end

    ifetch_unit #(
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Directed vectors: inputs applied this cycle, outputs observed this
    // cycle (before the edge that consumes the inputs).
    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic        e_data;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_fault;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic ed, input logic [31:0] epc,
                       input logic [31:0] einst, input logic ef, input logic [31:0] eipc);
        vec_t v;
        v = '{rst: r, rv: rv, rpc: rpc, rdy: rdy, e_valid: ev, e_data: ed,
              e_pc: epc, e_inst: einst, e_fault: ef, e_ipc: eipc};
        vecs.push_back(v);
    endtask

    // Hand-written reset sequence: pulse rst, then check the cleared state.
    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_pc", out_pc, 32'd0);
        check("reset out_inst", out_inst, 32'd0);
        check("reset fetch_fault", 32'(fetch_fault), 32'd0);
        check("reset imem_pc", imem_pc, 32'd0);
    endtask

    // Reference model: queue of pending fetches plus pc and fault flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_fault;

    function automatic bit legal(input logic [31:0] pc);
        return (pc % 4 == 0) && (longint'(pc) < longint'(4 * IMEM_WORDS));
    endfunction

    task automatic model_step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        int  had;
        bit  deq;
        ent_t e;
        if (r) begin
            mq.delete(); m_pc = 32'h0; m_fault = 0;
        end else begin
            had = mq.size();
            deq = (had > 0) && rdy;
            if (deq) void'(mq.pop_front());
            if (rv) begin
                mq.delete(); m_pc = rpc; m_fault = 0;
            end else if (!m_fault) begin
                if (!legal(m_pc)) begin
                    m_fault = 1;
                end else if (had < DEPTH || deq) begin
                    e.pc = m_pc;
                    e.inst = imem[m_pc[9:2]];
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        for (int i = 0; i < int'(IMEM_WORDS); i++) imem[i] = (i < 255) ? NOP_INST : 32'h0;
        imem[0] = I0; imem[1] = I1; imem[2] = I2; imem[3] = I3;

        // Streaming fetch
        add(0,0,0,1, 0,1,32'h0, 32'h0, 0,32'h0);
        add(0,0,0,1, 1,1,32'h0, I0, 0,32'h4);
        add(0,0,0,1, 1,1,32'h4, I1, 0,32'h8);
        add(0,0,0,1, 1,1,32'h8, I2, 0,32'hC);
        add(0,0,0,1, 1,1,32'hC, I3, 0,32'h10);
        add(1,0,0,0, 1,1,32'h10,NOP_INST, 0,32'h14);
        // Backpressure: five stalled cycles, then release
        add(0,0,0,0, 0,1,32'h0, 32'h0, 0,32'h0);
        add(0,0,0,0, 1,1,32'h0, I0, 0,32'h4);
        add(0,0,0,0, 1,1,32'h0, I0, 0,32'h8);
        add(0,0,0,0, 1,1,32'h0, I0, 0,32'h8);
        add(0,0,0,0, 1,1,32'h0, I0, 0,32'h8);
        add(0,0,0,1, 1,1,32'h0, I0, 0,32'h8);
        add(0,0,0,1, 1,1,32'h4, I1, 0,32'hC);
        add(1,0,0,0, 1,1,32'h8, I2, 0,32'h10);
        // Redirect to 0x8 while FIFO holds 0x0/0x4
        add(0,0,0,0, 0,1,32'h0, 32'h0, 0,32'h0);
        add(0,0,0,0, 1,1,32'h0, I0, 0,32'h4);
        add(0,1,32'h8,0, 1,1,32'h0, I0, 0,32'h8);
        add(0,0,0,0, 0,0,32'h0, 32'h0, 0,32'h8);
        add(0,0,0,1, 1,1,32'h8, I2, 0,32'hC);
        // Misaligned redirect with simultaneous deq, then recovery to 0x4
        add(0,1,32'h6,1, 1,1,32'hC, I3, 0,32'h10);
        add(0,0,0,1, 0,0,32'h0, 32'h0, 0,32'h6);
        add(0,0,0,1, 0,0,32'h0, 32'h0, 1,32'h6);
        add(0,0,0,1, 0,0,32'h0, 32'h0, 1,32'h6);
        add(0,1,32'h4,1, 0,0,32'h0, 32'h0, 1,32'h6);
        add(0,0,0,1, 0,0,32'h0, 32'h0, 0,32'h4);
        add(0,0,0,0, 1,1,32'h4, I1, 0,32'h8);
        // Out-of-range: last legal word, then fault with pc parked at 0x400
        add(0,1,32'h3FC,0, 1,1,32'h4, I1, 0,32'hC);
        add(0,0,0,0, 0,0,32'h0, 32'h0, 0,32'h3FC);
        add(0,0,0,0, 1,1,32'h3FC, 32'h0, 0,32'h400);
        add(0,0,0,0, 1,1,32'h3FC, 32'h0, 1,32'h400);
        add(0,0,0,1, 1,1,32'h3FC, 32'h0, 1,32'h400);
        add(0,0,0,1, 0,0,32'h0, 32'h0, 1,32'h400);
        // Reset mid-stream with two entries buffered
        add(0,1,32'h0,0, 0,0,32'h0, 32'h0, 1,32'h400);
        add(0,0,0,0, 0,0,32'h0, 32'h0, 0,32'h0);
        add(0,0,0,0, 1,1,32'h0, I0, 0,32'h4);
        add(1,0,0,0, 1,1,32'h0, I0, 0,32'h8);
        add(0,0,0,1, 0,1,32'h0, 32'h0, 0,32'h0);
        add(0,0,0,1, 1,1,32'h0, I0, 0,32'h4);

        @(negedge clk);
        do_reset();

        foreach (vecs[i]) begin
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d fetch_fault", i), 32'(fetch_fault), 32'(vecs[i].e_fault));
            check($sformatf("vec%0d imem_pc", i), imem_pc, vecs[i].e_ipc);
            if (vecs[i].e_data) begin
                check($sformatf("vec%0d out_pc", i), out_pc, vecs[i].e_pc);
                check($sformatf("vec%0d out_inst", i), out_inst, vecs[i].e_inst);
            end
            rst = vecs[i].rst; redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
            @(negedge clk);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < int'(IMEM_WORDS); i++) imem[i] = $urandom;
        do_reset();
        mq.delete(); m_pc = 32'h0; m_fault = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          r, rv, rdy;
            logic [31:0] rpc;
            check("rnd out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("rnd fetch_fault", 32'(fetch_fault), 32'(m_fault));
            check("rnd imem_pc", imem_pc, m_pc);
            if (mq.size() != 0) begin
                check("rnd out_pc", out_pc, mq[0].pc);
                check("rnd out_inst", out_inst, mq[0].inst);
            end
            r   = ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'($urandom_range(0, IMEM_WORDS - 1)) * 32'd4;
                1:       rpc = 32'h3F0 + 32'($urandom_range(0, 3)) * 32'd4;
                2:       rpc = 32'($urandom_range(0, IMEM_WORDS - 1)) * 32'd4 + 32'($urandom_range(1, 3));
                default: rpc = $urandom;
            endcase
            rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
            model_step(r, rv, rpc, rdy);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end; drives the address into the combinational instruction memory and consumes the returned word.
- Owns the program counter and advances it by 4 per fetch.
- Buffers fetched {pc, inst} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts redirects from branch/jump resolution and flushes wrong-path entries.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; power of 2, ≥ 2.
- IMEM_WORDS, 256, instruction memory rows; valid fetch range is pc < 4*IMEM_WORDS.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_pc  out  32  fetch address to instruction memory; equals the internal pc register.
- imem_inst  in  32  instruction word returned combinationally, same cycle as imem_pc.
- redirect_valid  in  1  single-cycle pulse: load redirect_pc.
- redirect_pc  in  32  new fetch target.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  head instruction.
- out_pc  out  32  PC of head instruction.
- fetch_fault  out  1  fetch halted on misaligned or out-of-range pc.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC; FIFO empty; state=FETCH.
  - out_valid=0, out_inst=0, out_pc=0, fetch_fault=0.
  - Reset mid-operation discards all buffered entries.
- States:
  - FETCH: normal operation.
  - FAULT: fetching halted.
- deq = out_valid & out_ready.
- can_enq = (count < FIFO_DEPTH) | deq. Pop-and-push on a full FIFO is allowed, so full throughput is 1 instr/cycle.
- In FETCH with no redirect, when can_enq is true and pc is legal:
  - push {pc, imem_inst};
  - pc <= pc+4 (32-bit wrap, never reached in practice due to the range check).
- Legal pc: pc[1:0]==2'b00 and pc < 4*IMEM_WORDS.
- Illegal pc in FETCH:
  - no push; transition to FAULT;
  - fetch_fault=1 from the next cycle;
  - entries already buffered still drain normally.
- FAULT:
  - no fetch; pc held;
  - exits only on redirect or rst.
- Redirect (redirect_valid=1) has highest priority, in any state:
  - FIFO flushed: count=0, out_valid=0 next cycle; any simultaneous deq is still honoured this cycle;
  - pc <= redirect_pc; no push this cycle;
  - state <= FETCH; fetch_fault cleared;
  - if redirect_pc is illegal, FAULT is entered on the following cycle via the normal check.
- Latency:
  - first out_valid one cycle after rst falls;
  - first post-redirect instruction valid two cycles after the redirect pulse.
- FIFO storage:
  - circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits, wrapping naturally;
  - count is log2(FIFO_DEPTH)+1 bits;
  - out_inst/out_pc come from the head entry; their value is don't-care when out_valid=0, except after reset (0).
- out_valid=0 with out_ready=1: no effect.
- Head entry is stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package/header holds:
  - XLEN=32, INST_W=32, PC_STEP=4;
  - state encodings FETCH=1'b0, FAULT=1'b1;
  - NOP encoding 32'h0000_0013.
- One natural sub-module, fetch_fifo: parameterised sync FIFO with push/pop/flush, full/empty, width 64 ({pc, inst}).
- PC/state logic stays in ifetch_unit.

Test Plan:
- Streaming fetch: reset, hold out_ready=1 over the standard 4-instruction program. Expect (out_pc, out_inst) = (0x0, 0x002081B3), (0x4, 0x404182B3), (0x8, 0x00532023), (0xC, 0x00032383) on consecutive cycles starting cycle 1.
- Backpressure: out_ready=0 for 5 cycles after reset.
  - Expect count saturates at 2, pc holds at 0x8, head stays (0x0, 0x002081B3).
  - After release: pc 0x0, 0x4, 0x8 delivered in order, no loss or duplication.
- Redirect with full FIFO: redirect_pc=0x8 while FIFO holds 0x0/0x4. Expect out_valid=0 next cycle, then (0x8, 0x00532023); the entries for 0x0/0x4 are never presented.
- Misaligned redirect: redirect_pc=0x6. Expect fetch_fault=1 two cycles later and out_valid stays 0. A later redirect to 0x4 clears fault and delivers (0x4, 0x404182B3).
- Out-of-range: redirect_pc=0x3FC. Expect (0x3FC, 0x00000000) delivered, then fetch_fault=1 with pc held at 0x400.
- Reset mid-stream: assert rst with 2 entries buffered. Expect out_valid=0 and fetch_fault=0 next cycle, then restart from (0x0, 0x002081B3).
